// File: rtl/pc_update_seq_if.sv
// PC-update stage bus: commit-side inputs from the memory stage, PC/status outputs toward fetch.
// The producer (commit logic) uses the master modport; the PC stage uses slave.
interface pc_update_seq_if #(
  parameter int unsigned PC_W = 64
);
  logic            commit;
  logic [3:0]      icode;
  logic            cnd;
  logic [PC_W-1:0] valC;
  logic [PC_W-1:0] valM;
  logic [PC_W-1:0] valP;
  logic [PC_W-1:0] pc;
  logic [1:0]      stat;
  logic            ras_miss;
  logic            ras_ovf;

  modport master (
    output commit, icode, cnd, valC, valM, valP,
    input  pc, stat, ras_miss, ras_ovf
  );

  modport slave (
    input  commit, icode, cnd, valC, valM, valP,
    output pc, stat, ras_miss, ras_ovf
  );
endinterface

// File: rtl/pc_update_seq.sv
// Y-86 PC-update stage: registered PC and sticky status, next PC chosen per retiring icode; 1-edge latency.
// No backpressure; commit=0 holds state. Optional return-address check stack enabled by PCU_RAS_EN.
module pc_update_seq #(
  parameter int unsigned      PC_W      = 64,
  parameter logic [PC_W-1:0]  RESET_PC  = '0,
  parameter int unsigned      RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_update_seq_if.slave    bus
);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_INS = 2'd2;

  localparam logic [3:0] IC_HALT = 4'h0;
  localparam logic [3:0] IC_JXX  = 4'h7;
  localparam logic [3:0] IC_CALL = 4'h8;
  localparam logic [3:0] IC_RET  = 4'h9;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_update_seq: RAS_DEPTH must be a power of two and at least 2");
  end

  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      stat_q, stat_d;
  logic            live;

  // Once halted or faulted, every commit is ignored until reset.
  assign live = bus.commit && (stat_q == STAT_AOK);

  always_comb begin
    pc_d   = pc_q;
    stat_d = stat_q;
    if (live) begin
      case (bus.icode)
        IC_HALT:                 stat_d = STAT_HLT;
        IC_JXX:                  pc_d   = bus.cnd ? bus.valC : bus.valP;
        IC_CALL:                 pc_d   = bus.valC;
        IC_RET:                  pc_d   = bus.valM;
        4'hC, 4'hD, 4'hE, 4'hF:  stat_d = STAT_INS;
        default:                 pc_d   = bus.valP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      stat_q <= STAT_AOK;
    end else begin
      pc_q   <= pc_d;
      stat_q <= stat_d;
    end
  end

  assign bus.pc   = pc_q;
  assign bus.stat = stat_q;

`ifdef PCU_RAS_EN
  localparam int unsigned  PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             miss_q, miss_d;
  logic             ovf_q, ovf_d;
  logic             is_call, is_ret;
  logic [PTR_W-1:0] last_idx;
  logic [PC_W-1:0]  popped;

  // top_q is the next free slot; when full it also addresses the oldest entry.
  assign is_call  = live && (bus.icode == IC_CALL);
  assign is_ret   = live && (bus.icode == IC_RET);
  assign last_idx = top_q - PTR_W'(1);
  assign popped   = ras_q[last_idx];

  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    miss_d = 1'b0;
    ovf_d  = ovf_q;
    if (is_call) begin
      top_d = top_q + PTR_W'(1);
      if (cnt_q == CNT_FULL) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + (PTR_W + 1)'(1);
      end
    end else if (is_ret) begin
      if (cnt_q == '0) begin
        miss_d = 1'b1;
      end else begin
        top_d  = last_idx;
        cnt_d  = cnt_q - (PTR_W + 1)'(1);
        miss_d = (popped != bus.valM);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q  <= '0;
      cnt_q  <= '0;
      miss_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      top_q  <= top_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
      ovf_q  <= ovf_d;
      if (is_call) begin
        ras_q[top_q] <= bus.valP;
      end
    end
  end

  assign bus.ras_miss = miss_q;
  assign bus.ras_ovf  = ovf_q;
`else
  assign bus.ras_miss = 1'b0;
  assign bus.ras_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_update_seq.sv
// Self-checking bench for pc_update_seq: a behavioural model fills a scoreboard queue per driven cycle.
// Second instance at PC_W=11 covers address wrap and asynchronous reset between edges.
module tb_pc_update_seq;
  localparam int unsigned DEPTH  = 8;
  localparam logic [63:0] RST_PC = 64'h100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_update_seq_if #(.PC_W(64)) bus ();
  pc_update_seq_if #(.PC_W(11)) wbus ();

  pc_update_seq #(.PC_W(64), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  pc_update_seq #(.PC_W(11), .RESET_PC(11'h100), .RAS_DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(wbus)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [1:0]  stat;
    logic        miss;
    logic        ovf;
  } obs_t;

  typedef struct {
    logic        c;
    logic [3:0]  ic;
    logic        cd;
    logic [63:0] vc;
    logic [63:0] vm;
    logic [63:0] vp;
  } stim_t;

  obs_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] m_pc;
  logic [1:0]  m_stat;
  logic        m_ovf;
  logic [63:0] m_ras[$];

  function automatic stim_t mk(input logic c, input logic [3:0] ic, input logic cd,
                               input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp);
    stim_t s;
    s.c = c; s.ic = ic; s.cd = cd; s.vc = vc; s.vm = vm; s.vp = vp;
    return s;
  endfunction

  task automatic model_reset();
    m_pc   = RST_PC;
    m_stat = 2'd0;
    m_ovf  = 1'b0;
    m_ras.delete();
  endtask

  // Drive one cycle at the falling edge, predict the outcome, wait until just after the rising edge.
  task automatic step(input stim_t s);
    obs_t e;
    logic miss = 1'b0;
    @(negedge clk);
    bus.commit = s.c; bus.icode = s.ic; bus.cnd = s.cd;
    bus.valC = s.vc; bus.valM = s.vm; bus.valP = s.vp;
    if (s.c && m_stat == 2'd0) begin
      case (s.ic)
        4'h0: m_stat = 2'd1;
        4'h7: m_pc = s.cd ? s.vc : s.vp;
        4'h8: begin
          m_pc = s.vc;
`ifdef PCU_RAS_EN
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(s.vp);
`endif
        end
        4'h9: begin
          m_pc = s.vm;
`ifdef PCU_RAS_EN
          if (m_ras.size() == 0) miss = 1'b1;
          else miss = (m_ras.pop_back() != s.vm);
`endif
        end
        4'hC, 4'hD, 4'hE, 4'hF: m_stat = 2'd2;
        default: m_pc = s.vp;
      endcase
    end
    e = '{pc: m_pc, stat: m_stat, miss: miss, ovf: m_ovf};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.commit = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    obs_t got, e;
    bus.commit = 1'b1; bus.icode = 4'h2; bus.valP = 64'h999;
    repeat (2) @(posedge clk);
    #1;
    got = '{pc: bus.pc, stat: bus.stat, miss: bus.ras_miss, ovf: bus.ras_ovf};
    e   = '{pc: RST_PC, stat: 2'd0, miss: 1'b0, ovf: 1'b0};
    n_checks++;
    if (got !== e) begin
      n_errors++;
      $display("FAIL reset_state: got pc=%h stat=%0d miss=%b ovf=%b, want pc=%h stat=0 miss=0 ovf=0",
               got.pc, got.stat, got.miss, got.ovf, e.pc);
    end
    @(negedge clk);
    bus.commit = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(mk(1'b0, 4'h2, 1'b0, 64'h0, 64'h0, 64'h44));
      got = '{pc: bus.pc, stat: bus.stat, miss: bus.ras_miss, ovf: bus.ras_ovf};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL reset_hold[%0d]: got pc=%h stat=%0d, want pc=%h stat=%0d", i, got.pc, got.stat, e.pc, e.stat);
      end
    end
  endtask

  task automatic test_seq();
    stim_t s[$];
    obs_t  got, e;
    s.push_back(mk(1'b1, 4'h2, 1'b0, 64'd0,  64'd0, 64'd2));
    s.push_back(mk(1'b1, 4'h3, 1'b0, 64'd0,  64'd0, 64'd10));
    s.push_back(mk(1'b1, 4'h7, 1'b1, 64'd13, 64'd0, 64'd14));
    s.push_back(mk(1'b1, 4'h7, 1'b0, 64'd16, 64'd0, 64'd15));
    s.push_back(mk(1'b1, 4'hA, 1'b0, 64'd99, 64'd98, 64'h20));
    s.push_back(mk(1'b1, 4'hB, 1'b1, 64'd99, 64'd98, 64'h28));
    s.push_back(mk(1'b1, 4'h1, 1'b1, 64'd99, 64'd98, 64'h30));
    s.push_back(mk(1'b1, 4'h6, 1'b1, 64'd99, 64'd98, 64'hFFFF_FFFF_FFFF_FFF0));
    s.push_back(mk(1'b0, 4'h4, 1'b1, 64'd99, 64'd98, 64'h5));
    foreach (s[i]) begin
      step(s[i]);
      got = '{pc: bus.pc, stat: bus.stat, miss: bus.ras_miss, ovf: bus.ras_ovf};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL seq[%0d]: got pc=%h stat=%0d miss=%b, want pc=%h stat=%0d miss=%b",
                 i, got.pc, got.stat, got.miss, e.pc, e.stat, e.miss);
      end
    end
  endtask

  task automatic test_call_ret();
    stim_t s[$];
    obs_t  got, e;
    s.push_back(mk(1'b1, 4'h8, 1'b0, 64'h40, 64'h0,  64'h20));
    s.push_back(mk(1'b1, 4'h9, 1'b0, 64'h0,  64'h20, 64'h0));
    s.push_back(mk(1'b1, 4'h9, 1'b0, 64'h0,  64'h30, 64'h0));
    s.push_back(mk(1'b0, 4'h9, 1'b0, 64'h0,  64'h30, 64'h0));
    s.push_back(mk(1'b1, 4'h8, 1'b0, 64'h80, 64'h0,  64'h50));
    s.push_back(mk(1'b1, 4'h9, 1'b0, 64'h0,  64'h54, 64'h0));
    s.push_back(mk(1'b1, 4'h2, 1'b0, 64'h0,  64'h0,  64'h60));
    foreach (s[i]) begin
      step(s[i]);
      got = '{pc: bus.pc, stat: bus.stat, miss: bus.ras_miss, ovf: bus.ras_ovf};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL call_ret[%0d]: got pc=%h miss=%b ovf=%b, want pc=%h miss=%b ovf=%b",
                 i, got.pc, got.miss, got.ovf, e.pc, e.miss, e.ovf);
      end
    end
  endtask

  task automatic test_overflow();
    stim_t s[$];
    obs_t  got, e;
    do_reset();
    for (int i = 1; i <= 9; i++) s.push_back(mk(1'b1, 4'h8, 1'b0, 64'h1000 + 64'(i), 64'h0, 64'(i)));
    for (int i = 9; i >= 1; i--) s.push_back(mk(1'b1, 4'h9, 1'b0, 64'h0, 64'(i), 64'h0));
    s.push_back(mk(1'b0, 4'h0, 1'b0, 64'h0, 64'h0, 64'h0));
    foreach (s[i]) begin
      step(s[i]);
      got = '{pc: bus.pc, stat: bus.stat, miss: bus.ras_miss, ovf: bus.ras_ovf};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL overflow[%0d]: got pc=%h miss=%b ovf=%b, want pc=%h miss=%b ovf=%b",
                 i, got.pc, got.miss, got.ovf, e.pc, e.miss, e.ovf);
      end
    end
  endtask

  task automatic test_halt_invalid();
    stim_t s[$];
    obs_t  got, e;
    do_reset();
    s.push_back(mk(1'b1, 4'h2, 1'b0, 64'h0,  64'h0,  64'h70));
    s.push_back(mk(1'b1, 4'h0, 1'b0, 64'h0,  64'h0,  64'h72));
    s.push_back(mk(1'b1, 4'h2, 1'b0, 64'h0,  64'h0,  64'h77));
    s.push_back(mk(1'b1, 4'h8, 1'b0, 64'h90, 64'h0,  64'h79));
    s.push_back(mk(1'b0, 4'h2, 1'b0, 64'h0,  64'h0,  64'h7A));
    foreach (s[i]) begin
      step(s[i]);
      got = '{pc: bus.pc, stat: bus.stat, miss: bus.ras_miss, ovf: bus.ras_ovf};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL halt[%0d]: got pc=%h stat=%0d, want pc=%h stat=%0d", i, got.pc, got.stat, e.pc, e.stat);
      end
    end
    do_reset();
    #1;
    n_checks++;
    if (bus.stat !== 2'd0 || bus.pc !== RST_PC) begin
      n_errors++;
      $display("FAIL halt_reset: got pc=%h stat=%0d, want pc=%h stat=0", bus.pc, bus.stat, RST_PC);
    end
    s.delete();
    s.push_back(mk(1'b1, 4'hE, 1'b0, 64'h0, 64'h0,  64'h11));
    s.push_back(mk(1'b1, 4'h9, 1'b0, 64'h0, 64'h33, 64'h0));
    s.push_back(mk(1'b1, 4'h7, 1'b1, 64'h5, 64'h0,  64'h6));
    foreach (s[i]) begin
      step(s[i]);
      got = '{pc: bus.pc, stat: bus.stat, miss: bus.ras_miss, ovf: bus.ras_ovf};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL invalid[%0d]: got pc=%h stat=%0d miss=%b, want pc=%h stat=%0d miss=%b",
                 i, got.pc, got.stat, got.miss, e.pc, e.stat, e.miss);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, e;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      step(mk(1'($urandom_range(0, 3) != 0), 4'($urandom_range(1, 11)), 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}));
      got = '{pc: bus.pc, stat: bus.stat, miss: bus.ras_miss, ovf: bus.ras_ovf};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL b2b[%0d]: got pc=%h stat=%0d miss=%b ovf=%b, want pc=%h stat=%0d miss=%b ovf=%b",
                 i, got.pc, got.stat, got.miss, got.ovf, e.pc, e.stat, e.miss, e.ovf);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    wbus.commit = 1'b1; wbus.icode = 4'h3; wbus.valP = 11'h7FF;
    @(posedge clk);
    #1;
    n_checks++;
    if (wbus.pc !== 11'h7FF) begin
      n_errors++;
      $display("FAIL wrap_top: got pc=%h, want pc=7ff", wbus.pc);
    end
    @(negedge clk);
    wbus.icode = 4'h7; wbus.cnd = 1'b1; wbus.valC = 11'h000; wbus.valP = 11'h001;
    @(posedge clk);
    #1;
    n_checks++;
    if (wbus.pc !== 11'h000) begin
      n_errors++;
      $display("FAIL wrap_zero: got pc=%h, want pc=000", wbus.pc);
    end
    @(negedge clk);
    wbus.commit = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wbus.pc !== 11'h100 || wbus.stat !== 2'd0) begin
      n_errors++;
      $display("FAIL async_reset: got pc=%h stat=%0d, want pc=100 stat=0", wbus.pc, wbus.stat);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.commit = 1'b0; bus.icode = 4'h0; bus.cnd = 1'b0;
    bus.valC = '0; bus.valM = '0; bus.valP = '0;
    wbus.commit = 1'b0; wbus.icode = 4'h0; wbus.cnd = 1'b0;
    wbus.valC = '0; wbus.valM = '0; wbus.valP = '0;
    model_reset();
    test_reset();
    test_seq();
    test_call_ret();
    test_overflow();
    test_halt_invalid();
    test_back_to_back();
    test_wrap();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
